mux_pipe_checker: RTL

- Receive-side companion to the team's two-stage registered mux pipeline (datapath: rg <= sel ? c : b; op <= sel ? c : a & rg).
- Taps the same a/b/c/sel inputs and the pipeline's op output.
- Runs a cycle-accurate internal model of the pipeline and flags every cycle where op disagrees with the model.
- Keeps sticky error status and saturating counters; optionally halts on the first error.

---
 rtl/mux_pipe_checker_pkg.sv | 26 ++
 rtl/mux_pipe_checker_model.sv | 28 ++
 rtl/mux_pipe_checker.sv | 86 ++++++++
 3 files changed

// File: rtl/mux_pipe_checker_pkg.sv
// Shared definitions for the mux pipeline checker: FSM encoding, counter
// width default and a saturating-increment helper.
package mux_pipe_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARM  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 16;

    // Width of the helper's arithmetic; counters up to this width are supported.
    localparam int SAT_W = 32;

    // Add one to val unless it already holds the all-ones value of a
    // width-bit counter; the caller truncates the result back to width bits.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input int               width);
        logic [SAT_W-1:0] max_val;
        max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
        return (val >= max_val) ? max_val : val + SAT_W'(1);
    endfunction

endpackage

// File: rtl/mux_pipe_checker_model.sv
// Cycle-accurate reference copy of the two-stage registered mux pipeline.
// Kept standalone so other checkers can reuse it.
module mux_pipe_model (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic sel,
    output logic exp_q
);

    logic rg_m;

    // Mirror the pipeline registers; unlike the real pipeline these are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rg_m  <= 1'b0;
            exp_q <= 1'b0;
        end else begin
            // NOTE: non-blocking, so exp_q below sees the pre-edge rg_m just
            // as the real second stage does.
            rg_m  <= sel ? c : b;
            exp_q <= sel ? c : (a & rg_m);
        end
    end

endmodule

// File: rtl/mux_pipe_checker.sv
// Receive-side checker for the two-stage mux pipeline: compares op against an
// internal model after a two-edge warm-up and keeps error status and counters.
// CNT_W must lie in 1..32.
module mux_pipe_checker
    import mux_pipe_checker_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             sel,
    input  logic             op,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic [1:0]       state_o
);

    state_t state_q;
    state_t state_d;
    logic   exp_q;
    logic   mismatch;

    mux_pipe_model u_model (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c     (c),
        .sel   (sel),
        .exp_q (exp_q)
    );

    assign mismatch = (state_q == ST_CHECK) && (op != exp_q);
    assign state_o  = state_q;

    // Next-state decode: warm-up, checking, optional halt on first error.
    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no
        // latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_WARM;
            ST_WARM:  state_d = en ? ST_CHECK : ST_IDLE;
            ST_CHECK: begin
                if (mismatch && STOP_ON_ERR && !clr) state_d = ST_HALT;
                else if (!en)                        state_d = ST_IDLE;
            end
            ST_HALT:  if (clr) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Error strobe, sticky flag and saturating counters; clr beats a mismatch.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_pulse    <= 1'b0;
            err_sticky   <= 1'b0;
            mismatch_cnt <= '0;
            check_cnt    <= '0;
        end else begin
            err_pulse <= mismatch;
            if (state_q == ST_CHECK) begin
                check_cnt <= CNT_W'(sat_inc(SAT_W'(check_cnt), CNT_W));
                if (mismatch) begin
                    mismatch_cnt <= CNT_W'(sat_inc(SAT_W'(mismatch_cnt), CNT_W));
                    err_sticky   <= 1'b1;
                end
            end
        end
    end

endmodule
